// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE / BUSY / RESP)
//   WORD_LSB  : bit position where the word index starts inside a byte address
//   CNT_W     : width of the wait-state counter (supports 0..15 wait states)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_LSB = 2;
  localparam int CNT_W    = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
// Synchronous write with enable and synchronous registered read on one shared
// index. Contents are never reset.
// Ports:
//   clk    in   clock
//   en     in   access enable (read happens whenever en=1)
//   we     in   write enable, qualified by en
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data (pre-write contents of idx)
module dmem_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Storage port: write and read share one index. The read register only
  // matters for loads; on a store its value is ignored by the responder.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port. Accepts one load or
// store at a time, waits WAIT_STATES cycles, then issues a single-cycle
// response carrying load data or a store acknowledge, plus an error flag for
// misaligned or out-of-range addresses.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_ready  out  request accepted this cycle if req_valid=1
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  load data; 0 for stores, errors and when rsp_valid=0
//   rsp_err    out  access error, valid with rsp_valid
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  lat_we;
  logic                  lat_err;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic                  accept;
  logic                  req_err;
  logic                  enter_resp;
  logic                  op_we;
  logic                  op_err;
  logic [IDX_W-1:0]      op_idx;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign accept  = (state == IDLE) && req_valid;
  assign req_err = (req_addr[WORD_LSB-1:0] != '0) ||
                   ((req_addr >> WORD_LSB) >= DATA_WIDTH'(DEPTH_WORDS));

  // With zero wait states the memory access happens on the acceptance edge,
  // before the request has been latched, so the live request is used instead.
  assign op_we    = NO_WAIT ? req_we                         : lat_we;
  assign op_err   = NO_WAIT ? req_err                        : lat_err;
  assign op_idx   = NO_WAIT ? req_addr[WORD_LSB +: IDX_W]    : lat_idx;
  assign op_wdata = NO_WAIT ? req_wdata                      : lat_wdata;

  assign enter_resp = ((state == BUSY) && (wait_cnt == '0)) || (NO_WAIT && accept);

  dmem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp && !op_err),
    .we    (op_we),
    .idx   (op_idx),
    .wdata (op_wdata),
    .rdata (mem_rdata)
  );

  // State register. Reset drops any pending operation without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture and wait-state countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_err   <= req_err;
      lat_idx   <= req_addr[WORD_LSB +: IDX_W];
      lat_wdata <= req_wdata;
      wait_cnt  <= NO_WAIT ? '0 : CNT_W'(WAIT_STATES - 1);
    end else if ((state == BUSY) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  // Next-state logic: RESP always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid) state_next = NO_WAIT ? RESP : BUSY;
      BUSY: if (wait_cnt == '0) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: data and error are forced to zero outside the response cycle.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && lat_err;
    rsp_rdata = '0;
    if ((state == RESP) && !lat_err && !lat_we) begin
      rsp_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Instance 0 uses two wait states,
// instance 1 uses none. Expected responses are queued when a request is
// accepted and compared when the responder strobes rsp_valid.
module tb_dmem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int   n_applied     = 0;
  int   n_miscompares = 0;
  int   cyc           = 0;
  bit   prev_valid [2];
  exp_t sb0 [$];
  exp_t sb1 [$];
  vec_t vecs [$];

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_applied++;
    if (act !== req) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard side: compare a strobed response with the oldest expectation,
  // and require zeroed outputs whenever no response is being strobed.
  task automatic checkOutput(input int d);
    exp_t x;
    bit   empty;
    int   lat;
    lat   = (d == 0) ? LAT0 : LAT1;
    empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
    if (rsp_valid[d]) begin
      if (empty) begin
        check($sformatf("dut%0d_unexpected_rsp", d), 32'd1, 32'd0);
      end else begin
        if (d == 0) x = sb0.pop_front();
        else        x = sb1.pop_front();
        check($sformatf("dut%0d_rsp_rdata", d), rsp_rdata[d], x.rdata);
        check($sformatf("dut%0d_rsp_err", d), 32'(rsp_err[d]), 32'(x.err));
        check($sformatf("dut%0d_rsp_latency", d), 32'(cyc - x.acc), 32'(lat));
      end
      check($sformatf("dut%0d_rsp_single_cycle", d), 32'(prev_valid[d]), 32'd0);
    end else begin
      check($sformatf("dut%0d_idle_rdata", d), rsp_rdata[d], 32'd0);
      check($sformatf("dut%0d_idle_err", d), 32'(rsp_err[d]), 32'd0);
    end
    prev_valid[d] = rsp_valid[d];
  endtask

  // Response monitor, sampling on the falling edge away from state changes.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n === 1'b1) checkOutput(d);
      else prev_valid[d] = 1'b0;
    end
  end

  // Drive one request, hold it until accepted, optionally queue its expectation.
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input bit expect_rsp);
    exp_t x;
    bit   ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    for (int t = 0; t < 20; t++) begin
      if (req_ready[d]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      x.rdata = exp_rdata;
      x.err   = exp_err;
      x.acc   = cyc + 1;
      if (expect_rsp) begin
        if (d == 0) sb0.push_back(x);
        else        sb1.push_back(x);
      end
      @(negedge clk);
    end else begin
      check($sformatf("dut%0d_accept_timeout", d), 32'd0, 32'd1);
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic waitDrain(input int d);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      #1;
      done = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
    end
    if (!done) check($sformatf("dut%0d_drain_timeout", d), 32'd0, 32'd1);
  endtask

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev_acc;
    bit ok;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      prev_valid[d] = 1'b0;
    end

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_reset_ready", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("dut%0d_reset_valid", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("dut%0d_reset_rdata", d), rsp_rdata[d], 32'd0);
      check($sformatf("dut%0d_reset_err", d), 32'(rsp_err[d]), 32'd0);
    end
    rst_n = 1'b1;

    // Two-wait-state vectors: stores, loads, errors, boundary words.
    vecs.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0042, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'h2222_2222, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0041, 32'h1111_1111, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0000_0055, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'h0000_0055, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0044, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1});

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b1);
      waitDrain(0);
    end

    // req_valid held high with stores alternating between two words:
    // one acceptance every four cycles.
    prev_acc = 0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (req_ready[0]) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        check("b2b_accept_timeout", 32'd0, 32'd1);
        break;
      end
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h100 + 32'(4 * (k % 2));
      req_wdata[0] = 32'h1000 + 32'(k);
      sb0.push_back('{32'h0, 1'b0, cyc + 1});
      if (k > 0) check("b2b_accept_gap", 32'(cyc + 1 - prev_acc), 32'd4);
      prev_acc = cyc + 1;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    waitDrain(0);
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 32'h1004, 1'b0, 1'b1);
    waitDrain(0);
    applyStimulus(0, 1'b0, 32'h104, 32'h0, 32'h1005, 1'b0, 1'b1);
    waitDrain(0);

    // Store to the last word interrupted by reset while BUSY.
    applyStimulus(0, 1'b1, 32'h3FC, 32'hBAD0_BAD0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready[0]), 32'd1);
    check("midrst_valid", 32'(rsp_valid[0]), 32'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("midrst_hold_valid", 32'(rsp_valid[0]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(0, 1'b0, 32'h3FC, 32'h0, 32'h0000_0055, 1'b0, 1'b1);
    waitDrain(0);

    // Zero-wait-state instance.
    applyStimulus(1, 1'b1, 32'h0, 32'h0000_0001, 32'h0, 1'b0, 1'b1);
    waitDrain(1);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 1'b1);
    waitDrain(1);
    applyStimulus(1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1'b1);
    waitDrain(1);
    applyStimulus(1, 1'b1, 32'h8, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    waitDrain(1);
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    waitDrain(1);
    applyStimulus(1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b1);
    waitDrain(1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
